cmp_search_ctrl: RTL and testbench



---
 rtl/cmp_search_ctrl.sv | 107 ++++++++++
 tb/tb_cmp_search_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator for a magnitude comparator: probes cmp_a and narrows [lo,hi] until the flags report equal.
// Each probe is held CMP_LAT cycles before the flags are sampled; start is ignored unless the controller is idle.
module cmp_search_ctrl #(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [WIDTH-1:0]              cmp_a,
  input  logic                          cmp_lower,
  input  logic                          cmp_equal,
  input  logic                          cmp_greater,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH-1:0]              result,
  output logic [$clog2(WIDTH+2)-1:0]    steps,
  output logic                          error
);

  localparam int SW = $clog2(WIDTH + 2);
  localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(CMP_LAT - 1);
  localparam logic [WIDTH:0]   HI_INIT  = (WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0] A_INIT   = WIDTH'((1 << (WIDTH - 1)) - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t         state;
  logic [WIDTH:0] lo, hi;
  logic [CW-1:0]  cnt;

  logic [WIDTH:0]   a_ext, nlo, nhi;
  logic [WIDTH-1:0] mid;
  logic             onehot, exhaust;

  assign a_ext  = {1'b0, cmp_a};
  assign onehot = ({cmp_lower, cmp_equal, cmp_greater} == 3'b100) ||
                  ({cmp_lower, cmp_equal, cmp_greater} == 3'b010) ||
                  ({cmp_lower, cmp_equal, cmp_greater} == 3'b001);

  // Bounds are one bit wider so lo can pass 2^WIDTH-1 and hi can wrap below 0.
  always_comb begin
    nlo = lo;
    nhi = hi;
    if (cmp_lower)   nlo = a_ext + (WIDTH+1)'(1);
    if (cmp_greater) nhi = a_ext - (WIDTH+1)'(1);
    exhaust = (nlo > nhi) || (cmp_greater && (cmp_a == '0));
    mid     = WIDTH'((nlo + nhi) >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cmp_a  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      steps  <= '0;
      error  <= 1'b0;
      lo     <= '0;
      hi     <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lo    <= '0;
            hi    <= HI_INIT;
            cmp_a <= A_INIT;
            steps <= '0;
            error <= 1'b0;
            busy  <= 1'b1;
            cnt   <= CNT_INIT;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            steps <= steps + SW'(1);
            // A valid one-hot non-equal answer only ends the search when the range is exhausted.
            if (!onehot || cmp_equal || exhaust) begin
              error  <= !(onehot && cmp_equal);
              result <= cmp_a;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              lo    <= nlo;
              hi    <= nhi;
              cmp_a <= mid;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Bench for cmp_search_ctrl: one instance at CMP_LAT=1, one at CMP_LAT=3, each driven by a modelled comparator.
module tb_cmp_search_ctrl;

  typedef struct {
    int          inst;
    logic [3:0]  key;
    int          mode;     // 0 real, 1 always lower, 2 no flags, 3 lower+equal
    logic [3:0]  res;
    int          stp;      // -1: sweep entry, steps only bounded
    logic        err;
    logic [23:0] probes;   // probe k in nibble k
    int          nprobe;   // -1: probe list not checked
  } exp_t;

  logic       clk;
  logic [1:0] rst_n, start;
  logic [3:0] key[2];
  int         mode[2];
  logic [3:0] cmp_a[2], result[2];
  logic [2:0] steps[2];
  logic       lower[2], equal[2], greater[2], busy[2], done[2], error[2];

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int          busy_cnt[2], runlen[2], nobs[2];
  logic [3:0]  prev_a[2];
  logic [23:0] obs[2];
  logic        chk_low[2];

  cmp_search_ctrl #(.WIDTH(4), .CMP_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .cmp_a(cmp_a[0]),
    .cmp_lower(lower[0]), .cmp_equal(equal[0]), .cmp_greater(greater[0]),
    .busy(busy[0]), .done(done[0]), .result(result[0]), .steps(steps[0]), .error(error[0])
  );

  cmp_search_ctrl #(.WIDTH(4), .CMP_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .cmp_a(cmp_a[1]),
    .cmp_lower(lower[1]), .cmp_equal(equal[1]), .cmp_greater(greater[1]),
    .busy(busy[1]), .done(done[1]), .result(result[1]), .steps(steps[1]), .error(error[1])
  );

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lower[i]   = 1'b0;
      equal[i]   = 1'b0;
      greater[i] = 1'b0;
      case (mode[i])
        0: begin
          lower[i]   = cmp_a[i] < key[i];
          equal[i]   = cmp_a[i] == key[i];
          greater[i] = cmp_a[i] > key[i];
        end
        1: lower[i] = 1'b1;
        2: ;
        default: begin
          lower[i] = 1'b1;
          equal[i] = 1'b1;
        end
      endcase
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(string name, int inst, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d", name, inst, act, expv);
    end
  endtask

  function automatic exp_t mk(int inst, logic [3:0] k, int m, logic [3:0] r, int s,
                              logic e, logic [23:0] p, int np);
    exp_t x;
    x.inst = inst; x.key = k; x.mode = m; x.res = r; x.stp = s;
    x.err = e; x.probes = p; x.nprobe = np;
    return x;
  endfunction

  // Monitor: records the probe sequence and hold times, scores each done against the queue.
  initial begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; runlen[i] = 0; nobs[i] = 0; obs[i] = '0; chk_low[i] = 1'b0; prev_a[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n[i]) begin
          busy_cnt[i] = 0; runlen[i] = 0; nobs[i] = 0; obs[i] = '0; chk_low[i] = 1'b0;
        end else begin
          if (chk_low[i]) begin
            chk("done_width", i, int'(done[i]), 0);
            chk_low[i] = 1'b0;
          end
          if (busy[i]) begin
            if (busy_cnt[i] == 0 || cmp_a[i] !== prev_a[i]) begin
              if (busy_cnt[i] != 0) chk("probe_hold", i, runlen[i], lat_of(i));
              if (nobs[i] < 6) obs[i][4*nobs[i] +: 4] = cmp_a[i];
              nobs[i]++;
              runlen[i] = 1;
            end else begin
              runlen[i]++;
            end
            prev_a[i] = cmp_a[i];
            busy_cnt[i]++;
          end
          if (done[i]) begin
            chk_low[i] = 1'b1;
            if (busy_cnt[i] != 0) chk("probe_hold", i, runlen[i], lat_of(i));
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done inst%0d: got done=1 expected no search", i);
            end else begin
              e = exp_q.pop_front();
              chk("inst", i, i, e.inst);
              chk("result", i, int'(result[i]), int'(e.res));
              chk("error", i, int'(error[i]), int'(e.err));
              if (e.stp >= 0) begin
                chk("steps", i, int'(steps[i]), e.stp);
                chk("latency", i, busy_cnt[i], e.stp * lat_of(i));
              end else begin
                chk("steps_vs_probes", i, int'(steps[i]), nobs[i]);
                chk("steps_le5", i, int'(steps[i] <= 3'd5), 1);
                chk("latency", i, busy_cnt[i], nobs[i] * lat_of(i));
              end
              if (e.nprobe >= 0) begin
                chk("nprobes", i, nobs[i], e.nprobe);
                chk("probes", i, int'(obs[i]), int'(e.probes));
              end
            end
            busy_cnt[i] = 0; runlen[i] = 0; nobs[i] = 0; obs[i] = '0;
          end
        end
      end
    end
  end

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d searches pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(exp_t e);
    key[e.inst]  = e.key;
    mode[e.inst] = e.mode;
    exp_q.push_back(e);
    @(negedge clk); start[e.inst] = 1'b1;
    @(negedge clk); start[e.inst] = 1'b0;
    drain();
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(string tag, int i);
    chk({tag, "_cmp_a"}, i, int'(cmp_a[i]), 0);
    chk({tag, "_busy"}, i, int'(busy[i]), 0);
    chk({tag, "_done"}, i, int'(done[i]), 0);
    chk({tag, "_result"}, i, int'(result[i]), 0);
    chk({tag, "_steps"}, i, int'(steps[i]), 0);
    chk({tag, "_error"}, i, int'(error[i]), 0);
  endtask

  exp_t tbl[8];

  initial begin
    tbl[0] = mk(0, 4'd5,  0, 4'd5,  3, 1'b0, 24'h000537, 3);
    tbl[1] = mk(0, 4'd15, 0, 4'd15, 5, 1'b0, 24'h0FEDB7, 5);
    tbl[2] = mk(0, 4'd0,  0, 4'd0,  4, 1'b0, 24'h000137, 4);
    tbl[3] = mk(0, 4'd8,  0, 4'd8,  4, 1'b0, 24'h0089B7, 4);
    tbl[4] = mk(0, 4'd0,  1, 4'd15, 5, 1'b1, 24'h0FEDB7, 5);
    tbl[5] = mk(0, 4'd3,  2, 4'd7,  1, 1'b1, 24'h000007, 1);
    tbl[6] = mk(0, 4'd3,  3, 4'd7,  1, 1'b1, 24'h000007, 1);
    tbl[7] = mk(0, 4'd9,  0, 4'd9,  3, 1'b0, 24'h0009B7, 3);

    start = '0;
    key[0] = '0; key[1] = '0;
    mode[0] = 0; mode[1] = 0;
    rst_n = '1;
    #2 rst_n = '0;
    #1;
    chk_zero("reset", 0);
    chk_zero("reset", 1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = '1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 8; t++) run(tbl[t]);

    for (int k = 0; k < 16; k++) run(mk(1, 4'(k), 0, 4'(k), -1, 1'b0, 24'h0, -1));

    // start held through busy and DONE cycles must not launch a second search
    key[0] = 4'd9; mode[0] = 0;
    exp_q.push_back(tbl[7]);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(negedge clk); start[0] = 1'b1;
    repeat (3) @(negedge clk);
    start[0] = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("ignored_start_busy", 0, int'(busy[0]), 0);
    chk("ignored_start_result", 0, int'(result[0]), 9);

    // reset during the second probe aborts with no done and no resume
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(posedge clk);
    #2 rst_n[0] = 1'b0;
    #1;
    chk_zero("abort", 0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_resume_busy", 0, int'(busy[0]), 0);
    chk("no_resume_cmp_a", 0, int'(cmp_a[0]), 0);

    run(tbl[7]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog");
  end

endmodule
